muldiv_iter: RTL and testbench

- Parametrised iterative multiply/divide unit.
- Next generation of the CPU's HI/LO arithmetic unit: runs MULT, MULTU, DIV and DIVU over a configurable operand width with a start/busy/done handshake.
- Sits beside the register file. The control unit raises start with the rs/rt operands; the hilo register path captures hi/lo when done pulses.

---
 rtl/muldiv_iter.sv | 151 +++++++++++++++
 tb/tb_muldiv_iter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide unit producing hi/lo results.
// Optional: define MULDIV_EARLY_TERM_EN to end multiplies early.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       fun_c,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int W = WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             bz;
  logic [W-1:0]     a_raw;
  logic [W-1:0]     mb_r;
  logic [2*W-1:0]   sh_r;
  logic [2*W-1:0]   acc_r;

  logic [W-1:0]     a_mag;
  logic [W-1:0]     b_mag;
  logic             accept;
  logic             last;
  logic [2*W-1:0]   acc_mul;
  logic [W:0]       rem_sh;
  logic [W:0]       diff;
  logic             ge;
  logic [W-1:0]     rem_nx;
  logic [W-1:0]     q_nx;
  logic [2*W-1:0]   prod_fx;
  logic [W-1:0]     hi_fx;
  logic [W-1:0]     lo_fx;

  assign a_mag  = (fun_c[0] && a[W-1]) ? -a : a;
  assign b_mag  = (fun_c[0] && b[W-1]) ? -b : b;
  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == CALC) || (state == FIX);
  assign done   = (state == DONE);

  // One datapath step plus the sign fix-up of the final result
  always_comb begin
    acc_mul = mb_r[0] ? (acc_r + sh_r) : acc_r;
    rem_sh  = {acc_r[2*W-1:W], acc_r[W-1]};
    diff    = rem_sh - {1'b0, mb_r};
    ge      = ~diff[W];
    rem_nx  = ge ? diff[W-1:0] : rem_sh[W-1:0];
    q_nx    = {acc_r[W-2:0], ge};
    last    = (cnt == CNT_W'(W - 1));
`ifdef MULDIV_EARLY_TERM_EN
    if (!is_div && mb_r[W-1:1] == '0)
      last = 1'b1;
`endif
    prod_fx = neg_q ? -acc_r : acc_r;
    if (!is_div) begin
      hi_fx = prod_fx[2*W-1:W];
      lo_fx = prod_fx[W-1:0];
    end else if (bz) begin
      hi_fx = a_raw;
      lo_fx = '1;
    end else begin
      hi_fx = neg_r ? -acc_r[2*W-1:W] : acc_r[2*W-1:W];
      lo_fx = neg_q ? -acc_r[W-1:0] : acc_r[W-1:0];
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = start ? CALC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      bz       <= 1'b0;
      a_raw    <= '0;
      mb_r     <= '0;
      sh_r     <= '0;
      acc_r    <= '0;
    end else if (accept) begin
      cnt    <= '0;
      is_div <= fun_c[1];
      neg_q  <= fun_c[0] & (a[W-1] ^ b[W-1]);
      neg_r  <= fun_c[0] & a[W-1];
      bz     <= (b == '0);
      a_raw  <= a;
      mb_r   <= b_mag;
      if (fun_c[1]) begin
        acc_r <= {{W{1'b0}}, a_mag};
        sh_r  <= '0;
      end else begin
        acc_r <= '0;
        sh_r  <= {{W{1'b0}}, a_mag};
      end
    end else if (state == CALC) begin
      cnt <= cnt + CNT_W'(1);
      if (is_div) begin
        acc_r <= {rem_nx, q_nx};
      end else begin
        acc_r <= acc_mul;
        sh_r  <= sh_r << 1;
        mb_r  <= mb_r >> 1;
      end
    end else if (state == FIX) begin
      hi       <= hi_fx;
      lo       <= lo_fx;
      div_zero <= is_div & bz;
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter (WIDTH=32).
// Expected latencies follow MULDIV_EARLY_TERM_EN when defined.
module tb_muldiv_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  fun_c = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int tests = 0;
  int fails = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;
  logic        prev_dz = 1'b0;

  muldiv_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .fun_c(fun_c),
    .a(a),
    .b(b),
    .hi(hi),
    .lo(lo),
    .busy(busy),
    .done(done),
    .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input string tag,
                        input logic [1:0] f,
                        input logic [31:0] aa,
                        input logic [31:0] bb,
                        input logic [31:0] ehi,
                        input logic [31:0] elo,
                        input logic edz,
                        input int dfull,
                        input int dearly,
                        input int inj);
    int dexp;
    int dcyc;
    logic bok;
`ifdef MULDIV_EARLY_TERM_EN
    dexp = dearly;
`else
    dexp = dfull;
`endif
    dcyc = 0;
    bok = 1'b1;
    fun_c = f;
    a = aa;
    b = bb;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h0BAD_F00D;
    fun_c = ~f;
    chk({tag, "/hold_hi"}, {32'h0, hi}, {32'h0, prev_hi});
    chk({tag, "/hold_lo"}, {32'h0, lo}, {32'h0, prev_lo});
    chk({tag, "/hold_dz"}, {63'h0, div_zero},
        {63'h0, prev_dz});
    for (int c = 1; c <= 80 && dcyc == 0; c++) begin
      if (done) dcyc = c;
      if (done == busy) bok = 1'b0;
      if (c == inj) begin
        start = 1'b1;
        fun_c = 2'b00;
        a = 32'd1;
        b = 32'd1;
      end else begin
        start = 1'b0;
      end
      if (dcyc == 0) tick();
    end
    start = 1'b0;
    chk({tag, "/done_cyc"}, 64'(dcyc), 64'(dexp));
    chk({tag, "/busy"}, {63'h0, bok}, 64'h1);
    chk({tag, "/hi"}, {32'h0, hi}, {32'h0, ehi});
    chk({tag, "/lo"}, {32'h0, lo}, {32'h0, elo});
    chk({tag, "/dz"}, {63'h0, div_zero}, {63'h0, edz});
    tick();
    chk({tag, "/pulse"}, {62'h0, done, busy}, 64'h0);
    chk({tag, "/keep_lo"}, {32'h0, lo}, {32'h0, elo});
    prev_hi = ehi;
    prev_lo = elo;
    prev_dz = edz;
  endtask

  initial begin
    int dn;
    reset = 1'b0;
    repeat (3) tick();
    chk("rst/hi", {32'h0, hi}, 64'h0);
    chk("rst/lo", {32'h0, lo}, 64'h0);
    chk("rst/busy", {63'h0, busy}, 64'h0);
    chk("rst/done", {63'h0, done}, 64'h0);
    chk("rst/dz", {63'h0, div_zero}, 64'h0);
    reset = 1'b1;
    tick();

    run_op("multu_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 34, 0);
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 5, 0);
    run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 34, 0);
    run_op("divu_z", 2'b10, 32'h1234_5678, 32'd0,
           32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 34, 34, 0);
    run_op("multu_2x3", 2'b00, 32'd2, 32'd3,
           32'h0, 32'd6, 1'b0, 34, 4, 0);
    run_op("div_z", 2'b11, 32'hFFFF_FFF0, 32'd0,
           32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 34, 34, 0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 32'h8000_0000, 1'b0, 34, 34, 0);
    run_op("divu_inj", 2'b10, 32'd100, 32'd7,
           32'd2, 32'd14, 1'b0, 34, 34, 5);
    run_op("multu_5x3", 2'b00, 32'd5, 32'd3,
           32'h0, 32'd15, 1'b0, 34, 4, 0);

    fun_c = 2'b01;
    a = 32'd5;
    b = 32'h4000_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("abort/busy_pre", {63'h0, busy}, 64'h1);
    reset = 1'b0;
    tick();
    chk("abort/busy", {63'h0, busy}, 64'h0);
    chk("abort/done", {63'h0, done}, 64'h0);
    chk("abort/hi", {32'h0, hi}, 64'h0);
    chk("abort/lo", {32'h0, lo}, 64'h0);
    reset = 1'b1;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) dn++;
    end
    chk("abort/no_done", 64'(dn), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
